// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Moore control FSM for a multi-cycle RV32I-subset datapath with one shared
//   ALU and one unified instruction/data memory. Every instruction walks
//   FETCH -> DECODE -> (execute states) and returns to FETCH; unsupported
//   encodings park in TRAP until reset.
//
//   Ports
//     clk, reset          rising-edge clock, async active-high reset (-> IDLE)
//     opcode/funct3/      decode fields from the instruction register
//     funct7b5
//     zero, sign          ALU flags, only consulted in BRANCH
//     mem_ready           memory access completes this cycle
//     pc_write, ir_write, adr_src, mem_write, reg_write     datapath enables
//     result_src, alu_src_a, alu_src_b, imm_src, alu_control datapath selects
//     instr_retired       one-cycle pulse in the last state of an instruction
//     trap                high while in TRAP
//     state_dbg           state encoding (values of state_t below)
module multicycle_controller #(
    parameter bit RESET_TO_IDLE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       sign,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       instr_retired,
    output logic       trap,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_EXECI    = 4'd8,
        S_ALUWB    = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    state_t state_q, state_d;

    // {supported, alu op}. SRA (101 with funct7b5) and SLTU (011) are not
    // implemented and fall to TRAP. Immediate forms ignore funct7b5 for 000
    // because bit 30 there is part of the immediate, not a SUB select.
    function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                              input logic       f7b5,
                                              input logic       is_r);
        logic [3:0] r;
        r = {1'b0, ALU_ADD};
        case (f3)
            3'b000:  r = {1'b1, (is_r && f7b5) ? ALU_SUB : ALU_ADD};
            3'b111:  r = {1'b1, ALU_AND};
            3'b110:  r = {1'b1, ALU_OR};
            3'b100:  r = {1'b1, ALU_XOR};
            3'b010:  r = {1'b1, ALU_SLT};
            3'b001:  r = {1'b1, ALU_SLL};
            3'b101:  r = {!f7b5, ALU_SRL};
            default: r = {1'b0, ALU_ADD};
        endcase
        return r;
    endfunction

    logic [3:0] alu_r, alu_i;
    logic       br_ok, br_taken;

    assign alu_r = alu_decode(funct3, funct7b5, 1'b1);
    assign alu_i = alu_decode(funct3, funct7b5, 1'b0);

    // BRANCH compares rs1 - rs2; only beq/bne/blt/bge are supported
    always_comb begin
        br_ok    = 1'b1;
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = zero;
            3'b001:  br_taken = !zero;
            3'b100:  br_taken = sign;
            3'b101:  br_taken = !sign;
            default: br_ok    = 1'b0;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_TRAP;
                endcase
            end
            // bit 5 separates store (0100011) from load (0000011)
            S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECR:    state_d = alu_r[3] ? S_ALUWB : S_TRAP;
            S_EXECI:    state_d = alu_i[3] ? S_ALUWB : S_TRAP;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = br_ok ? S_FETCH : S_TRAP;
            S_JAL:      state_d = S_ALUWB;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_IDLE;
        endcase
    end

    // With RESET_TO_IDLE=0 the register resets straight into FETCH; the output
    // decode below is blanked while reset is high so enables stay quiet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= RESET_TO_IDLE ? S_IDLE : S_FETCH;
        else       state_q <= state_d;
    end

    // Output decode
    always_comb begin
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        adr_src       = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        imm_src       = 2'b00;
        alu_control   = ALU_ADD;
        instr_retired = 1'b0;
        trap          = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                end
                S_DECODE: begin
                    // branch target into ALUOut; JAL needs the J immediate
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                    imm_src   = (opcode == OP_JAL) ? 2'b11 : 2'b10;
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    imm_src   = opcode[5] ? 2'b01 : 2'b00;
                end
                S_MEMREAD: begin
                    adr_src = 1'b1;
                end
                S_MEMWB: begin
                    result_src    = 2'b01;
                    reg_write     = 1'b1;
                    instr_retired = 1'b1;
                end
                S_MEMWRITE: begin
                    adr_src       = 1'b1;
                    mem_write     = 1'b1;
                    instr_retired = mem_ready;
                end
                S_EXECR: begin
                    alu_src_a   = 2'b10;
                    alu_control = alu_r[2:0];
                end
                S_EXECI: begin
                    alu_src_a   = 2'b10;
                    alu_src_b   = 2'b01;
                    alu_control = alu_i[2:0];
                end
                S_ALUWB: begin
                    reg_write     = 1'b1;
                    instr_retired = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 2'b10;
                    alu_control   = ALU_SUB;
                    pc_write      = br_ok && br_taken;
                    instr_retired = br_ok;
                end
                S_JAL: begin
                    // PC <- ALUOut (target), ALU computes old_pc + 4
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    pc_write  = 1'b1;
                end
                S_TRAP:  trap = 1'b1;
                default: ;
            endcase
        end
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    localparam logic [3:0] IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEMADR = 4'd3,
                           MEMREAD = 4'd4, MEMWB = 4'd5, MEMWRITE = 4'd6, EXECR = 4'd7,
                           EXECI = 4'd8, ALUWB = 4'd9, BRANCH = 4'd10, JAL = 4'd11,
                           TRAP = 4'd12;

    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_SYS = 7'b1110011;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       funct7b5 = 1'b0, zero = 1'b0, sign = 1'b0, mem_ready = 1'b1;
    logic       pc_write, ir_write, adr_src, mem_write, reg_write, instr_retired, trap;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic [3:0] state_dbg;

    int checks = 0;
    int errors = 0;

    multicycle_controller #(.RESET_TO_IDLE(1'b1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .sign(sign), .mem_ready(mem_ready), .pc_write(pc_write),
        .ir_write(ir_write), .adr_src(adr_src), .mem_write(mem_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_src(imm_src), .alu_control(alu_control), .instr_retired(instr_retired),
        .trap(trap), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // {pcw, irw, adr, mw, rw, rs[2], sa[2], sb[2], imm[2], alu[3], ret, trap}
    function automatic logic [17:0] o(input logic pcw, input logic irw, input logic adr,
                                      input logic mw, input logic rw, input logic [1:0] rs,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [1:0] imm, input logic [2:0] alu,
                                      input logic ret, input logic trp);
        return {pcw, irw, adr, mw, rw, rs, sa, sb, imm, alu, ret, trp};
    endfunction

    logic [17:0] act;
    assign act = {pc_write, ir_write, adr_src, mem_write, reg_write, result_src, alu_src_a,
                  alu_src_b, imm_src, alu_control, instr_retired, trap};

    typedef struct {
        string       name;
        logic        rst;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic        s;
        logic        mr;
        logic [3:0]  st;
        logic [17:0] out;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic rst, input logic [6:0] op,
                       input logic [2:0] f3, input logic f7, input logic z, input logic s,
                       input logic mr, input logic [3:0] st, input logic [17:0] out);
        vec_t v;
        v.name = name; v.rst = rst; v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.s = s;
        v.mr = mr; v.st = st; v.out = out;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [3:0] exp_st, input logic [17:0] exp_out);
        checks++;
        if (state_dbg !== exp_st || act !== exp_out) begin
            errors++;
            $display("FAIL %s: state=%0d outs=%b, required state=%0d outs=%b",
                     name, state_dbg, act, exp_st, exp_out);
        end
    endtask

    task automatic chk_st(input string name, input logic [3:0] exp_st, input logic exp_trap);
        checks++;
        if (state_dbg !== exp_st || trap !== exp_trap) begin
            errors++;
            $display("FAIL %s: state=%0d trap=%b, required state=%0d trap=%b",
                     name, state_dbg, trap, exp_st, exp_trap);
        end
    endtask

    task automatic step(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic mr);
        @(posedge clk); #1;
        opcode = op; funct3 = f3; funct7b5 = f7; mem_ready = mr;
        @(negedge clk);
    endtask

    logic [17:0] Z, F1, F0, DEC, DECJ, WB, MWB, MRD, MW0, MW1, TRP;

    initial begin
        Z    = o(0,0,0,0,0,2'd0,2'd0,2'd0,2'd0,3'd0,0,0);
        F1   = o(1,1,0,0,0,2'd2,2'd0,2'd2,2'd0,3'd0,0,0);
        F0   = o(0,0,0,0,0,2'd2,2'd0,2'd2,2'd0,3'd0,0,0);
        DEC  = o(0,0,0,0,0,2'd0,2'd1,2'd1,2'd2,3'd0,0,0);
        DECJ = o(0,0,0,0,0,2'd0,2'd1,2'd1,2'd3,3'd0,0,0);
        WB   = o(0,0,0,0,1,2'd0,2'd0,2'd0,2'd0,3'd0,1,0);
        MWB  = o(0,0,0,0,1,2'd1,2'd0,2'd0,2'd0,3'd0,1,0);
        MRD  = o(0,0,1,0,0,2'd0,2'd0,2'd0,2'd0,3'd0,0,0);
        MW0  = o(0,0,1,1,0,2'd0,2'd0,2'd0,2'd0,3'd0,0,0);
        MW1  = o(0,0,1,1,0,2'd0,2'd0,2'd0,2'd0,3'd0,1,0);
        TRP  = o(0,0,0,0,0,2'd0,2'd0,2'd0,2'd0,3'd0,0,1);

        // reset, then add
        add("rst0",   1, 7'd0, 3'd0, 0, 0, 0, 1, IDLE, Z);
        add("rst1",   1, 7'd0, 3'd0, 0, 0, 0, 1, IDLE, Z);
        add("rst2",   1, 7'd0, 3'd0, 0, 0, 0, 1, IDLE, Z);
        add("idle",   0, OP_R, 3'd0, 0, 0, 0, 1, IDLE, Z);
        add("add_f",  0, OP_R, 3'd0, 0, 0, 0, 1, FETCH, F1);
        add("add_d",  0, OP_R, 3'd0, 0, 0, 0, 1, DECODE, DEC);
        add("add_x",  0, OP_R, 3'd0, 0, 0, 0, 1, EXECR, o(0,0,0,0,0,2'd0,2'd2,2'd0,2'd0,3'd0,0,0));
        add("add_wb", 0, OP_R, 3'd0, 0, 0, 0, 1, ALUWB, WB);
        // sub
        add("sub_f",  0, OP_R, 3'd0, 1, 0, 0, 1, FETCH, F1);
        add("sub_d",  0, OP_R, 3'd0, 1, 0, 0, 1, DECODE, DEC);
        add("sub_x",  0, OP_R, 3'd0, 1, 0, 0, 1, EXECR, o(0,0,0,0,0,2'd0,2'd2,2'd0,2'd0,3'd1,0,0));
        add("sub_wb", 0, OP_R, 3'd0, 1, 0, 0, 1, ALUWB, WB);
        // lw with two wait cycles in MEMREAD: 7 cycles
        add("lw_f",   0, OP_LOAD, 3'd2, 0, 0, 0, 1, FETCH, F1);
        add("lw_d",   0, OP_LOAD, 3'd2, 0, 0, 0, 1, DECODE, DEC);
        add("lw_a",   0, OP_LOAD, 3'd2, 0, 0, 0, 1, MEMADR, o(0,0,0,0,0,2'd0,2'd2,2'd1,2'd0,3'd0,0,0));
        add("lw_r0",  0, OP_LOAD, 3'd2, 0, 0, 0, 0, MEMREAD, MRD);
        add("lw_r1",  0, OP_LOAD, 3'd2, 0, 0, 0, 0, MEMREAD, MRD);
        add("lw_r2",  0, OP_LOAD, 3'd2, 0, 0, 0, 1, MEMREAD, MRD);
        add("lw_wb",  0, OP_LOAD, 3'd2, 0, 0, 0, 1, MEMWB, MWB);
        // beq taken, bne not taken (zero=1)
        add("beq_f",  0, OP_BR, 3'd0, 0, 1, 0, 1, FETCH, F1);
        add("beq_d",  0, OP_BR, 3'd0, 0, 1, 0, 1, DECODE, DEC);
        add("beq_b",  0, OP_BR, 3'd0, 0, 1, 0, 1, BRANCH, o(1,0,0,0,0,2'd0,2'd2,2'd0,2'd0,3'd1,1,0));
        add("bne_f",  0, OP_BR, 3'd1, 0, 1, 0, 1, FETCH, F1);
        add("bne_d",  0, OP_BR, 3'd1, 0, 1, 0, 1, DECODE, DEC);
        add("bne_b",  0, OP_BR, 3'd1, 0, 1, 0, 1, BRANCH, o(0,0,0,0,0,2'd0,2'd2,2'd0,2'd0,3'd1,1,0));
        // sw with one wait cycle
        add("sw_f",   0, OP_STORE, 3'd2, 0, 0, 0, 1, FETCH, F1);
        add("sw_d",   0, OP_STORE, 3'd2, 0, 0, 0, 1, DECODE, DEC);
        add("sw_a",   0, OP_STORE, 3'd2, 0, 0, 0, 1, MEMADR, o(0,0,0,0,0,2'd0,2'd2,2'd1,2'd1,3'd0,0,0));
        add("sw_w0",  0, OP_STORE, 3'd2, 0, 0, 0, 0, MEMWRITE, MW0);
        add("sw_w1",  0, OP_STORE, 3'd2, 0, 0, 0, 1, MEMWRITE, MW1);
        // ori with a fetch stall; funct7b5 set must not matter
        add("ori_f0", 0, OP_I, 3'd6, 1, 0, 0, 0, FETCH, F0);
        add("ori_f1", 0, OP_I, 3'd6, 1, 0, 0, 1, FETCH, F1);
        add("ori_d",  0, OP_I, 3'd6, 1, 0, 0, 1, DECODE, DEC);
        add("ori_x",  0, OP_I, 3'd6, 1, 0, 0, 1, EXECI, o(0,0,0,0,0,2'd0,2'd2,2'd1,2'd0,3'd3,0,0));
        add("ori_wb", 0, OP_I, 3'd6, 1, 0, 0, 1, ALUWB, WB);
        // addi with bit30 set stays ADD
        add("addi_f", 0, OP_I, 3'd0, 1, 0, 0, 1, FETCH, F1);
        add("addi_d", 0, OP_I, 3'd0, 1, 0, 0, 1, DECODE, DEC);
        add("addi_x", 0, OP_I, 3'd0, 1, 0, 0, 1, EXECI, o(0,0,0,0,0,2'd0,2'd2,2'd1,2'd0,3'd0,0,0));
        add("addi_wb",0, OP_I, 3'd0, 1, 0, 0, 1, ALUWB, WB);
        // jal
        add("jal_f",  0, OP_JAL, 3'd0, 0, 0, 0, 1, FETCH, F1);
        add("jal_d",  0, OP_JAL, 3'd0, 0, 0, 0, 1, DECODE, DECJ);
        add("jal_j",  0, OP_JAL, 3'd0, 0, 0, 0, 1, JAL, o(1,0,0,0,0,2'd0,2'd1,2'd2,2'd0,3'd0,0,0));
        add("jal_wb", 0, OP_JAL, 3'd0, 0, 0, 0, 1, ALUWB, WB);
        // blt taken on sign
        add("blt_f",  0, OP_BR, 3'd4, 0, 0, 1, 1, FETCH, F1);
        add("blt_d",  0, OP_BR, 3'd4, 0, 0, 1, 1, DECODE, DEC);
        add("blt_b",  0, OP_BR, 3'd4, 0, 0, 1, 1, BRANCH, o(1,0,0,0,0,2'd0,2'd2,2'd0,2'd0,3'd1,1,0));
        // unsupported opcode -> TRAP from cycle 3, held; reset recovers
        add("sys_f",  0, OP_SYS, 3'd0, 0, 0, 0, 1, FETCH, F1);
        add("sys_d",  0, OP_SYS, 3'd0, 0, 0, 0, 1, DECODE, DEC);
        add("sys_t0", 0, OP_SYS, 3'd0, 0, 0, 0, 1, TRAP, TRP);
        add("sys_t1", 0, OP_SYS, 3'd0, 0, 0, 0, 1, TRAP, TRP);
        add("sys_t2", 0, 7'd0,   3'd0, 0, 0, 0, 1, TRAP, TRP);
        add("trp_rst",1, 7'd0,   3'd0, 0, 0, 0, 1, IDLE, Z);
        add("rel_idl",0, OP_R,   3'd0, 0, 0, 0, 1, IDLE, Z);
        add("rel_f",  0, OP_R,   3'd0, 0, 0, 0, 1, FETCH, F1);

        // Table run: inputs change just after the rising edge, outputs are
        // sampled on the falling edge.
        @(negedge clk);
        foreach (vecs[i]) begin
            @(posedge clk); #1;
            reset = vecs[i].rst; opcode = vecs[i].op; funct3 = vecs[i].f3;
            funct7b5 = vecs[i].f7; zero = vecs[i].z; sign = vecs[i].s;
            mem_ready = vecs[i].mr;
            @(negedge clk);
            chk(vecs[i].name, vecs[i].st, vecs[i].out);
        end

        // sra is unsupported: EXECR -> TRAP
        step(OP_R, 3'd5, 1'b1, 1'b1); chk_st("sra_d", DECODE, 1'b0);
        step(OP_R, 3'd5, 1'b1, 1'b1); chk_st("sra_x", EXECR, 1'b0);
        step(OP_R, 3'd5, 1'b1, 1'b1); chk_st("sra_t", TRAP, 1'b1);

        // reset is asynchronous: checked well before the next clock edge
        #1 reset = 1'b1;
        #1 chk("async_rst_trap", IDLE, Z);
        @(posedge clk); #1 reset = 1'b0;

        // bgeu not supported: BRANCH does not write the PC or retire, then TRAP
        step(OP_BR, 3'd7, 1'b0, 1'b1); chk_st("bgeu_f", FETCH, 1'b0);
        step(OP_BR, 3'd7, 1'b0, 1'b1); chk_st("bgeu_d", DECODE, 1'b0);
        step(OP_BR, 3'd7, 1'b0, 1'b1);
        chk("bgeu_b", BRANCH, o(0,0,0,0,0,2'd0,2'd2,2'd0,2'd0,3'd1,0,0));
        step(OP_BR, 3'd7, 1'b0, 1'b1); chk("bgeu_t", TRAP, TRP);

        // reset while a load waits in MEMREAD: no writeback, back to IDLE
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        step(OP_LOAD, 3'd2, 1'b0, 1'b1); chk_st("lw2_f", FETCH, 1'b0);
        step(OP_LOAD, 3'd2, 1'b0, 1'b1); chk_st("lw2_d", DECODE, 1'b0);
        step(OP_LOAD, 3'd2, 1'b0, 1'b1); chk_st("lw2_a", MEMADR, 1'b0);
        step(OP_LOAD, 3'd2, 1'b0, 1'b0); chk("lw2_r", MEMREAD, MRD);
        #1 reset = 1'b1;
        #1 chk("async_rst_memread", IDLE, Z);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk); chk("post_rst_idle", IDLE, Z);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
